// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the timer_dev countdown
//                timer. Holds the FSM state encoding, register offsets,
//                CTRL field positions, MODE encodings and the byte-lane
//                merge helper used by byte-enabled writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  // Timer state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } st_t;

  // Register word offsets (addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL field layout; only the low CTRL_W bits are stored
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings; 2 and 3 are treated as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  // Replace each byte of old_val whose enable bit is set with the byte of new_val
  function automatic logic [31:0] be_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage : timer_pkg

`default_nettype wire

// File: rtl/timer_dev.sv
// ============================================================================
//  Module      : timer_dev
//  Description : Memory-mapped countdown timer behind the processor bridge.
//                Registers CTRL / PRESET / COUNT, a four-state countdown FSM
//                and an interrupt request (irq = IM & PEND).
//                Optional build macro TIMER_BYTE_WRITE_EN: when defined,
//                CTRL and PRESET honour per-byte write enables; otherwise
//                any write replaces the full word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_dev
  import timer_pkg::*;
#(
  parameter int PRESET_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [PRESET_W-1:0] c_one = PRESET_W'(1);

  st_t                 st_q, st_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [PRESET_W-1:0] preset_q, preset_d;
  logic [PRESET_W-1:0] count_q, count_d;
  logic                pend_q, pend_d;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [3:0]  w_be;
  logic        w_en;
  logic        w_auto;
  logic [CTRL_W-1:0]   w_ctrl_new;
  logic [PRESET_W-1:0] w_preset_new;

  assign w_wr_ctrl   = we && (addr == OFF_CTRL);
  assign w_wr_preset = we && (addr == OFF_PRESET);
  assign w_en        = ctrl_q[CTRL_EN];
  assign w_auto      = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

`ifdef TIMER_BYTE_WRITE_EN
  assign w_be = be;
`else
  // Every lane enabled: any write replaces the whole register
  assign w_be = be | 4'hF;
`endif

  // Post-write register images after byte-lane merging
  assign w_ctrl_new   = CTRL_W'(be_merge(32'(ctrl_q), wdata, w_be));
  assign w_preset_new = PRESET_W'(be_merge(32'(preset_q), wdata, w_be));

  // Next-state logic: FSM update first, then CPU writes override it
  always_comb begin
    st_d     = st_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    // Auto-reload PEND lives for exactly one cycle
    if (pend_q && w_auto) begin
      pend_d = 1'b0;
    end

    case (st_q)
      ST_IDLE: begin
        if (w_en) begin
          st_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        st_d    = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          st_d = ST_IDLE;
        end else if (count_q > c_one) begin
          count_d = count_q - c_one;
        end else begin
          // Saturate at zero rather than wrapping
          count_d = '0;
          st_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (w_auto) begin
          st_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          st_d            = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    // Any write to CTRL or PRESET acknowledges the interrupt, even with be=0
    if (w_wr_ctrl || w_wr_preset) begin
      pend_d = 1'b0;
    end

    // Entering-INT set beats a same-cycle acknowledge
    if (st_q == ST_INT) begin
      pend_d = 1'b1;
    end

    if (w_wr_ctrl) begin
      ctrl_d = w_ctrl_new;
      if (!w_ctrl_new[CTRL_EN]) begin
        st_d = ST_IDLE;
      end
    end

    // COUNT only picks up a new PRESET at the next LOAD
    if (w_wr_preset) begin
      preset_d = w_preset_new;
    end
  end

  // State and register flops, asynchronously cleared by active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  // Zero-latency read mux; unused upper bits and the reserved offset read 0
  always_comb begin
    rdata = '0;
    case (addr)
      OFF_CTRL:   rdata = 32'(ctrl_q);
      OFF_PRESET: rdata = 32'(preset_q);
      OFF_COUNT:  rdata = 32'(count_q);
      default:    rdata = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & pend_q;

endmodule : timer_dev

`default_nettype wire

// File: tb/tb_timer_dev.sv
// ============================================================================
//  Module      : tb_timer_dev
//  Description : Self-checking bench for timer_dev. A table of per-cycle
//                vectors covers reset, one-shot and auto-reload operation;
//                hand-written sequences cover freeze-on-disable, PRESET=0,
//                byte-enabled writes and asynchronous reset mid-operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

`ifdef TIMER_BYTE_WRITE_EN
  localparam logic [31:0] EXP_BE0  = 32'h0000_0000;
  localparam logic [31:0] EXP_BYTE = 32'h1122_CC44;
`else
  localparam logic [31:0] EXP_BE0  = 32'h0000_0077;
  localparam logic [31:0] EXP_BYTE = 32'hAABB_CCDD;
`endif

  timer_dev #(.PRESET_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = w; v.addr = a; v.be = 4'hF; v.wdata = d; v.exp_rdata = er; v.exp_irq = ei;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check 1 time unit later
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    #1;
    chk({name, "_rdata"}, rdata, v.exp_rdata);
    chk({name, "_irq"}, {31'b0, irq}, {31'b0, v.exp_irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic [31:0] er, input logic ei, input string name);
    vec_t v;
    v.we = 1'b1; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er; v.exp_irq = ei;
    apply(v, name);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] er, input logic ei,
                    input string name);
    vec_t v;
    v.we = 1'b0; v.addr = a; v.be = 4'hF; v.wdata = '0; v.exp_rdata = er; v.exp_irq = ei;
    apply(v, name);
  endtask

  initial begin
    logic found;

    reset = 1'b0; addr = 2'd0; we = 1'b0; be = 4'hF; wdata = '0;

    // Reset state: all offsets read 0
    add(0, 2'd0, 0, 32'd0, 0);
    add(0, 2'd1, 0, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    add(0, 2'd3, 0, 32'd0, 0);
    // One-shot: PRESET=5, CTRL=0x9
    add(1, 2'd1, 5,     32'd0, 0);
    add(1, 2'd0, 32'h9, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);   // IDLE
    add(0, 2'd2, 0, 32'd0, 0);   // LOAD
    add(0, 2'd2, 0, 32'd5, 0);
    add(0, 2'd2, 0, 32'd4, 0);
    add(0, 2'd2, 0, 32'd3, 0);
    add(0, 2'd2, 0, 32'd2, 0);
    add(0, 2'd2, 0, 32'd1, 0);
    add(0, 2'd2, 0, 32'd0, 0);   // INT
    add(0, 2'd0, 0, 32'h8, 1);   // EN cleared, irq high
    add(0, 2'd2, 0, 32'd0, 1);   // irq stays high
    add(1, 2'd0, 32'h8, 32'h8, 1);
    add(0, 2'd0, 0, 32'h8, 0);   // acknowledged
    // Auto-reload: PRESET=3, CTRL=0xB
    add(1, 2'd1, 3,     32'd5, 0);
    add(1, 2'd0, 32'hB, 32'h8, 0);
    add(0, 2'd2, 0, 32'd0, 0);   // IDLE
    add(0, 2'd2, 0, 32'd0, 0);   // LOAD
    add(0, 2'd2, 0, 32'd3, 0);
    add(0, 2'd2, 0, 32'd2, 0);
    add(0, 2'd2, 0, 32'd1, 0);
    add(0, 2'd2, 0, 32'd0, 0);   // INT
    add(0, 2'd2, 0, 32'd0, 1);   // LOAD, pulse
    add(0, 2'd2, 0, 32'd3, 0);
    add(0, 2'd2, 0, 32'd2, 0);
    add(0, 2'd2, 0, 32'd1, 0);
    add(0, 2'd2, 0, 32'd0, 0);   // INT
    add(0, 2'd2, 0, 32'd0, 1);   // LOAD, pulse
    add(0, 2'd2, 0, 32'd3, 0);
    add(1, 2'd2, 32'hFF, 32'd2, 0);    // COUNT is read-only
    add(0, 2'd2, 0, 32'd1, 0);
    add(1, 2'd3, 32'hFFFF, 32'd0, 0);  // reserved offset, INT
    add(0, 2'd3, 0, 32'd0, 1);         // LOAD, pulse
    add(1, 2'd0, 32'h0, 32'hB, 0);     // disable during CNT (count 3)
    add(0, 2'd0, 0, 32'h0, 0);
    add(0, 2'd2, 0, 32'd2, 0);
    add(0, 2'd2, 0, 32'd2, 0);         // held in IDLE

    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Freeze: disable while COUNT=100
    wr(2'd1, 32'd102, 4'hF, 32'd3, 0, "frz_preset");
    wr(2'd0, 32'h9,   4'hF, 32'd0, 0, "frz_ctrl");
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      we = 1'b0; addr = 2'd2;
      #1;
      if (rdata === 32'd100) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL frz_wait: got no COUNT=100 expected COUNT=100 within 20 cycles");
    end
    #1;
    addr = 2'd0; we = 1'b1; be = 4'hF; wdata = 32'h8;
    rd(2'd2, 32'd99, 0, "frz_cnt0");
    rd(2'd2, 32'd99, 0, "frz_cnt1");
    rd(2'd0, 32'h8,  0, "frz_ctrl_rb");

    // PRESET=0: LOAD -> CNT -> INT
    wr(2'd1, 32'd0, 4'hF, 32'd102, 0, "p0_preset");
    wr(2'd0, 32'h9, 4'hF, 32'h8,   0, "p0_ctrl");
    rd(2'd2, 32'd99, 0, "p0_idle");
    rd(2'd2, 32'd99, 0, "p0_load");
    rd(2'd2, 32'd0,  0, "p0_cnt");
    rd(2'd2, 32'd0,  0, "p0_int");
    rd(2'd0, 32'h8,  1, "p0_irq");

    // Write with be=0 still acknowledges the interrupt
    wr(2'd1, 32'h77, 4'h0, 32'd0, 1, "be0_wr");
    rd(2'd1, EXP_BE0, 0, "be0_rb");

    // Byte-lane write to PRESET
    wr(2'd1, 32'h1122_3344, 4'hF,    EXP_BE0,      0, "byte_full");
    wr(2'd1, 32'hAABB_CCDD, 4'b0010, 32'h1122_3344, 0, "byte_lane");
    rd(2'd1, EXP_BYTE, 0, "byte_rb");

    // Asynchronous reset while irq is high
    wr(2'd1, 32'd3, 4'hF, EXP_BYTE, 0, "rst_preset");
    wr(2'd0, 32'hB, 4'hF, 32'h8,    0, "rst_ctrl_wr");
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      we = 1'b0; addr = 2'd0;
      #1;
      if (irq === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL rst_wait: got irq=0 expected irq=1 within 20 cycles");
    end
    reset = 1'b0;
    #1;
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_ctrl", rdata, 32'd0);
    addr = 2'd1;
    #1;
    chk("rst_preset_rb", rdata, 32'd0);
    addr = 2'd2;
    #1;
    chk("rst_count", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd(2'd0, 32'd0, 0, "post_rst_ctrl");
    rd(2'd2, 32'd0, 0, "post_rst_count");
    rd(2'd1, 32'd0, 0, "post_rst_preset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_timer_dev

`default_nettype wire
